// File: rtl/weight_tile_loader_pkg.sv
// Shared hyper-parameters for the weight tile loader: FIFO word width, tile geometry defaults, FSM encoding.
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif

package weight_tile_loader_pkg;
  localparam int TILE_WORDS_DEFAULT = 16;
  localparam int NUM_TILES_DEFAULT  = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2,
    DONE    = 2'd3
  } load_state_t;

  // Index width that stays legal when the range holds a single entry.
  function automatic int index_bits(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/weight_tile_bank.sv
// Tile storage bank: one register per slot, written one slot per cycle, read back as a flat tile.
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif

module weight_tile_bank
  import weight_tile_loader_pkg::*;
#(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int TILE_WORDS = TILE_WORDS_DEFAULT,
  parameter int SLOT_W     = index_bits(TILE_WORDS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wr_en,
  input  logic [SLOT_W-1:0]                wr_slot,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  output logic [TILE_WORDS*DATA_WIDTH-1:0] tile
);
  genvar gi;
  for (gi = 0; gi < TILE_WORDS; gi++) begin : g_slot
    logic [DATA_WIDTH-1:0] word_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        word_reg <= '0;
      end else if (wr_en && (wr_slot == SLOT_W'(gi))) begin
        word_reg <= wr_data;
      end
    end

    assign tile[gi*DATA_WIDTH +: DATA_WIDTH] = word_reg;
  end
endmodule

// File: rtl/weight_tile_loader.sv
// Weight tile loader: pops weight-FIFO words into a tile bank and hands complete tiles to the PE array.
// Define WEIGHT_TILE_LOADER_DOUBLE_BUF_EN to fill the next tile in a second bank while one is presented.
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif

module weight_tile_loader
  import weight_tile_loader_pkg::*;
#(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int TILE_WORDS = TILE_WORDS_DEFAULT,
  parameter int NUM_TILES  = NUM_TILES_DEFAULT
) (
  input  logic                             s_clk,
  input  logic                             s_rst_n,
  input  logic                             i_start,
  input  logic [DATA_WIDTH-1:0]            i_weight_data,
  input  logic                             i_weight_ready,
  output logic                             o_weight_rd,
  output logic [TILE_WORDS*DATA_WIDTH-1:0] o_tile_data,
  output logic                             o_tile_valid,
  input  logic                             i_tile_ready,
  output logic [$clog2(NUM_TILES)-1:0]     o_tile_idx,
  output logic                             o_load_w_finish,
  output logic                             o_busy
);
  localparam int SLOT_W = index_bits(TILE_WORDS);
  localparam int CNT_W  = $clog2(TILE_WORDS + 1);
  localparam int IDX_W  = $clog2(NUM_TILES);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(TILE_WORDS - 1);
  localparam logic [IDX_W-1:0]  LAST_TILE = IDX_W'(NUM_TILES - 1);

  load_state_t       state_reg;
  logic [CNT_W-1:0]  pop_cnt_reg;
  logic              wr_en_reg;
  logic [SLOT_W-1:0] wr_slot_reg;
  logic              last_wr;

  // FIFO data trails the pop by one cycle, so the write strobe and slot are delayed to match.
  assign last_wr = wr_en_reg && (wr_slot_reg == LAST_SLOT);
  assign o_busy  = (state_reg != IDLE);

`ifndef WEIGHT_TILE_LOADER_DOUBLE_BUF_EN
  assign o_weight_rd = (state_reg == FETCH) && i_weight_ready &&
                       (pop_cnt_reg < CNT_W'(TILE_WORDS));

  weight_tile_bank #(
    .DATA_WIDTH(DATA_WIDTH),
    .TILE_WORDS(TILE_WORDS),
    .SLOT_W    (SLOT_W)
  ) u_bank (
    .clk    (s_clk),
    .rst_n  (s_rst_n),
    .wr_en  (wr_en_reg),
    .wr_slot(wr_slot_reg),
    .wr_data(i_weight_data),
    .tile   (o_tile_data)
  );

  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_reg       <= IDLE;
      pop_cnt_reg     <= '0;
      wr_en_reg       <= 1'b0;
      wr_slot_reg     <= '0;
      o_tile_idx      <= '0;
      o_tile_valid    <= 1'b0;
      o_load_w_finish <= 1'b0;
    end else begin
      wr_en_reg       <= o_weight_rd;
      wr_slot_reg     <= pop_cnt_reg[SLOT_W-1:0];
      o_load_w_finish <= 1'b0;
      if (o_weight_rd) begin
        pop_cnt_reg <= pop_cnt_reg + 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (i_start) begin
            state_reg   <= FETCH;
            pop_cnt_reg <= '0;
            o_tile_idx  <= '0;
          end
        end
        FETCH: begin
          if (last_wr) begin
            o_tile_valid <= 1'b1;
            state_reg    <= PRESENT;
          end
        end
        PRESENT: begin
          if (i_tile_ready) begin
            o_tile_valid <= 1'b0;
            if (o_tile_idx == LAST_TILE) begin
              state_reg       <= DONE;
              o_load_w_finish <= 1'b1;
            end else begin
              o_tile_idx  <= o_tile_idx + 1'b1;
              pop_cnt_reg <= '0;
              state_reg   <= FETCH;
            end
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end
`else
  localparam int FT_W = $clog2(NUM_TILES + 1);
  localparam logic [CNT_W-1:0] LAST_POP = CNT_W'(TILE_WORDS - 1);

  logic                             fill_sel_reg;
  logic                             pres_sel_reg;
  logic                             wr_bank_reg;
  logic [1:0]                       bank_full_reg;
  logic [FT_W-1:0]                  fill_tiles_reg;
  logic [TILE_WORDS*DATA_WIDTH-1:0] bank_tile [2];
  logic                             pres_ready;
  logic                             next_ready;

  // Filling runs in FETCH and PRESENT alike; it stops only when the bank it targets still holds a tile.
  assign o_weight_rd = ((state_reg == FETCH) || (state_reg == PRESENT)) && i_weight_ready &&
                       !bank_full_reg[fill_sel_reg] && (fill_tiles_reg < FT_W'(NUM_TILES));
  assign pres_ready  = bank_full_reg[pres_sel_reg] || (last_wr && (wr_bank_reg == pres_sel_reg));
  assign next_ready  = bank_full_reg[~pres_sel_reg] || (last_wr && (wr_bank_reg != pres_sel_reg));
  assign o_tile_data = bank_tile[pres_sel_reg];

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_bank
    weight_tile_bank #(
      .DATA_WIDTH(DATA_WIDTH),
      .TILE_WORDS(TILE_WORDS),
      .SLOT_W    (SLOT_W)
    ) u_bank (
      .clk    (s_clk),
      .rst_n  (s_rst_n),
      .wr_en  (wr_en_reg && (wr_bank_reg == 1'(gi))),
      .wr_slot(wr_slot_reg),
      .wr_data(i_weight_data),
      .tile   (bank_tile[gi])
    );
  end

  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_reg       <= IDLE;
      pop_cnt_reg     <= '0;
      wr_en_reg       <= 1'b0;
      wr_slot_reg     <= '0;
      wr_bank_reg     <= 1'b0;
      fill_sel_reg    <= 1'b0;
      pres_sel_reg    <= 1'b0;
      bank_full_reg   <= '0;
      fill_tiles_reg  <= '0;
      o_tile_idx      <= '0;
      o_tile_valid    <= 1'b0;
      o_load_w_finish <= 1'b0;
    end else begin
      wr_en_reg       <= o_weight_rd;
      wr_slot_reg     <= pop_cnt_reg[SLOT_W-1:0];
      wr_bank_reg     <= fill_sel_reg;
      o_load_w_finish <= 1'b0;
      if (o_weight_rd) begin
        if (pop_cnt_reg == LAST_POP) begin
          pop_cnt_reg    <= '0;
          fill_sel_reg   <= ~fill_sel_reg;
          fill_tiles_reg <= fill_tiles_reg + 1'b1;
        end else begin
          pop_cnt_reg <= pop_cnt_reg + 1'b1;
        end
      end
      if (last_wr) begin
        bank_full_reg[wr_bank_reg] <= 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (i_start) begin
            state_reg      <= FETCH;
            pop_cnt_reg    <= '0;
            fill_sel_reg   <= 1'b0;
            pres_sel_reg   <= 1'b0;
            bank_full_reg  <= '0;
            fill_tiles_reg <= '0;
            o_tile_idx     <= '0;
          end
        end
        FETCH: begin
          if (pres_ready) begin
            o_tile_valid <= 1'b1;
            state_reg    <= PRESENT;
          end
        end
        PRESENT: begin
          if (i_tile_ready) begin
            bank_full_reg[pres_sel_reg] <= 1'b0;
            pres_sel_reg                <= ~pres_sel_reg;
            if (o_tile_idx == LAST_TILE) begin
              o_tile_valid    <= 1'b0;
              state_reg       <= DONE;
              o_load_w_finish <= 1'b1;
            end else begin
              o_tile_idx <= o_tile_idx + 1'b1;
              // Next tile already complete: keep valid high for a back-to-back handshake.
              if (!next_ready) begin
                o_tile_valid <= 1'b0;
                state_reg    <= FETCH;
              end
            end
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end
`endif
endmodule

// File: tb/tb_weight_tile_loader.sv
// Self-checking bench for weight_tile_loader: FIFO model feeds a scoreboard checked at each tile handshake.
`timescale 1ns/1ps

module tb_weight_tile_loader;
  localparam int DW = 64;
  localparam int TW = 16;
  localparam int NT = 2;
  localparam int IW = $clog2(NT);
`ifdef WEIGHT_TILE_LOADER_DOUBLE_BUF_EN
  localparam int STALL_POPS = 2 * TW;
`else
  localparam int STALL_POPS = TW;
`endif

  logic             s_clk = 1'b0;
  logic             s_rst_n = 1'b0;
  logic             i_start = 1'b0;
  logic [DW-1:0]    i_weight_data = '0;
  logic             i_weight_ready = 1'b0;
  logic             o_weight_rd;
  logic [TW*DW-1:0] o_tile_data;
  logic             o_tile_valid;
  logic             i_tile_ready = 1'b0;
  logic [IW-1:0]    o_tile_idx;
  logic             o_load_w_finish;
  logic             o_busy;

  weight_tile_loader #(
    .DATA_WIDTH(DW),
    .TILE_WORDS(TW),
    .NUM_TILES (NT)
  ) dut (
    .s_clk          (s_clk),
    .s_rst_n        (s_rst_n),
    .i_start        (i_start),
    .i_weight_data  (i_weight_data),
    .i_weight_ready (i_weight_ready),
    .o_weight_rd    (o_weight_rd),
    .o_tile_data    (o_tile_data),
    .o_tile_valid   (o_tile_valid),
    .i_tile_ready   (i_tile_ready),
    .o_tile_idx     (o_tile_idx),
    .o_load_w_finish(o_load_w_finish),
    .o_busy         (o_busy)
  );

  always #5 s_clk = ~s_clk;

  int            vec_cnt = 0;
  int            err_cnt = 0;
  int            cyc = 0;
  int            pop_total = 0;
  int            finish_total = 0;
  int            hs_total = 0;
  int            exp_idx = 0;
  bit            pop_pend = 1'b0;
  logic          prev_valid = 1'b0;
  logic [DW-1:0] fifo_val = '0;
  logic [DW-1:0] exp_q[$];
  int            pop_cyc_q[$];
  int            vrise_q[$];
  int            base_pop, base_fin, base_hs;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge s_clk);
    cyc++;
  end

  // FIFO model: the word for a pop appears just after the edge that registered the pop.
  initial forever begin
    @(posedge s_clk);
    #1;
    if (pop_pend) begin
      i_weight_data = fifo_val;
      exp_q.push_back(fifo_val);
      fifo_val++;
    end
  end

  // Mid-cycle monitor: counts pops/finish pulses and scores every accepted tile.
  initial forever begin
    @(negedge s_clk);
    pop_pend = s_rst_n && o_weight_rd;
    if (pop_pend) begin
      pop_total++;
      pop_cyc_q.push_back(cyc);
    end
    if (s_rst_n && o_load_w_finish) finish_total++;
    if (o_tile_valid && !prev_valid) vrise_q.push_back(cyc);
    prev_valid = o_tile_valid;
    if (s_rst_n && o_tile_valid && i_tile_ready) begin
      hs_total++;
      $display("tile accepted: idx %0d at cycle %0d", o_tile_idx, cyc);
      check("tile_idx", 64'(o_tile_idx), 64'(exp_idx));
      exp_idx = (exp_idx + 1) % NT;
      if (exp_q.size() < TW) begin
        check("tile_words_avail", 64'(exp_q.size()), 64'(TW));
      end else begin
        for (int k = 0; k < TW; k++) begin
          logic [DW-1:0] w;
          w = exp_q.pop_front();
          check($sformatf("tile_word%0d", k), o_tile_data[k*DW +: DW], w);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge s_clk);
      #2;
    end
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick(1);
    i_start = 1'b0;
  endtask

  task automatic new_matrix();
    exp_q.delete();
    pop_cyc_q.delete();
    vrise_q.delete();
    fifo_val = '0;
    exp_idx  = 0;
    base_pop = pop_total;
    base_fin = finish_total;
    base_hs  = hs_total;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (o_busy && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, 64'(o_busy), 64'd0);
  endtask

  task automatic wait_pops(input string tag, input int target, input int budget);
    int n = 0;
    while ((pop_total - base_pop) < target && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, 64'(pop_total - base_pop), 64'(target));
  endtask

  task automatic end_matrix(input string tag);
    check({tag, "_pops"},     64'(pop_total - base_pop), 64'(NT * TW));
    check({tag, "_finish"},   64'(finish_total - base_fin), 64'd1);
    check({tag, "_tiles"},    64'(hs_total - base_hs), 64'(NT));
    check({tag, "_leftover"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_valid_low"}, 64'(o_tile_valid), 64'd0);
  endtask

  initial begin
    logic [TW*DW-1:0] snap_data;
    logic [IW-1:0]    snap_idx;
    int               gap_base;

    // Reset state
    tick(3);
    check("rst_rd",     64'(o_weight_rd), 64'd0);
    check("rst_valid",  64'(o_tile_valid), 64'd0);
    check("rst_finish", 64'(o_load_w_finish), 64'd0);
    check("rst_busy",   64'(o_busy), 64'd0);
    check("rst_data",   64'(o_tile_data != '0), 64'd0);
    check("rst_idx",    64'(o_tile_idx), 64'd0);
    s_rst_n = 1'b1;
    tick(2);

    // Uninterrupted ready on both sides
    i_weight_ready = 1'b1;
    i_tile_ready   = 1'b1;
    new_matrix();
    pulse_start();
    wait_idle("s1_done", 300);
    end_matrix("s1");
    check("s1_contig",  64'(pop_cyc_q[TW-1] - pop_cyc_q[0]), 64'(TW - 1));
    check("s1_latency", 64'(vrise_q[0] - pop_cyc_q[0]), 64'(TW + 1));

    // Weight FIFO runs low for 5 cycles after the 7th pop
    new_matrix();
    pulse_start();
    wait_pops("s2_reach7", 7, 100);
    i_weight_ready = 1'b0;
    gap_base = pop_total;
    tick(5);
    check("s2_gap_pops", 64'(pop_total - gap_base), 64'd0);
    i_weight_ready = 1'b1;
    wait_idle("s2_done", 300);
    end_matrix("s2");
    check("s2_latency", 64'(vrise_q[0] - pop_cyc_q[0]), 64'(TW + 1 + 5));

    // PE array back-pressure for 20 cycles
    i_tile_ready = 1'b0;
    new_matrix();
    pulse_start();
    begin
      int n = 0;
      while (!o_tile_valid && n < 100) begin
        tick(1);
        n++;
      end
    end
    check("s3_valid_seen", 64'(o_tile_valid), 64'd1);
    snap_data = o_tile_data;
    snap_idx  = o_tile_idx;
    for (int c = 0; c < 20; c++) begin
      tick(1);
      check("s3_data_stable", 64'(o_tile_data !== snap_data), 64'd0);
      check("s3_idx_stable",  64'(o_tile_idx), 64'(snap_idx));
    end
    check("s3_stall_pops", 64'(pop_total - base_pop), 64'(STALL_POPS));
    i_tile_ready = 1'b1;
    wait_idle("s3_done", 300);
    end_matrix("s3");

    // Stray start during FETCH is ignored
    new_matrix();
    pulse_start();
    tick(3);
    pulse_start();
    wait_idle("s4_done", 300);
    end_matrix("s4");
    tick(5);
    check("s4_stays_idle", 64'(o_busy), 64'd0);

    // Reset after pop 9 of tile 1, then a clean restart
    new_matrix();
    pulse_start();
    wait_pops("s5_reach", TW + 10, 200);
    s_rst_n = 1'b0;
    #1;
    check("s5_rst_rd",     64'(o_weight_rd), 64'd0);
    check("s5_rst_valid",  64'(o_tile_valid), 64'd0);
    check("s5_rst_busy",   64'(o_busy), 64'd0);
    check("s5_rst_data",   64'(o_tile_data != '0), 64'd0);
    check("s5_rst_idx",    64'(o_tile_idx), 64'd0);
    tick(3);
    check("s5_no_finish",  64'(finish_total - base_fin), 64'd0);
    check("s5_rst_finish", 64'(o_load_w_finish), 64'd0);
    check("s5_tiles_pre",  64'(hs_total - base_hs), 64'd1);
    s_rst_n = 1'b1;
    tick(2);
    new_matrix();
    pulse_start();
    wait_idle("s5_done", 300);
    end_matrix("s5");
    check("s5_latency", 64'(vrise_q[0] - pop_cyc_q[0]), 64'(TW + 1));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/weight_tile_loader.md
WEIGHT_TILE_LOADER -- requirements
Module: weight_tile_loader

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default `DATA_WIDTH (64): width of one weight-FIFO word, 8 int8 weights.
REQ-002 The block SHALL have parameter TILE_WORDS, default 16: FIFO words per tile, legal range 1..64.
REQ-003 The block SHALL have parameter NUM_TILES, default 32: tiles per weight matrix, minimum 2.
REQ-004 The block SHALL have port s_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port s_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port i_start, input, 1 bit: one-cycle pulse that begins loading one matrix.
REQ-007 The block SHALL have port i_weight_data, input, DATA_WIDTH bits: weight FIFO dout, valid one cycle after a pop (standard-mode FIFO).
REQ-008 The block SHALL have port i_weight_ready, input, 1 bit: weight FIFO not-almost-empty (at least 64 words held).
REQ-009 The block SHALL have port o_weight_rd, output, 1 bit: weight FIFO read enable.
REQ-010 The block SHALL have port o_tile_data, output, TILE_WORDS*DATA_WIDTH bits: assembled tile, word 0 in the LSBs.
REQ-011 The block SHALL have port o_tile_valid, output, 1 bit: tile available to the PE array.
REQ-012 The block SHALL have port i_tile_ready, input, 1 bit: PE array accepts the tile.
REQ-013 The block SHALL have port o_tile_idx, output, $clog2(NUM_TILES) bits: index of the presented tile.
REQ-014 The block SHALL have port o_load_w_finish, output, 1 bit: one-cycle pulse at matrix end, wired to the weight FIFO's load_w_finish.
REQ-015 The block SHALL have port o_busy, output, 1 bit: high in any state except IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, FETCH, PRESENT and DONE.
REQ-017 In IDLE, i_start SHALL move the FSM to FETCH with the tile index and word counter cleared; i_start in any other state SHALL be ignored.
REQ-018 In FETCH, o_weight_rd SHALL be asserted exactly in the cycles where i_weight_ready=1 and fewer than TILE_WORDS pops have been issued for the current tile; when i_weight_ready=0 the block SHALL pause without losing count.
REQ-019 The word returned for pop k SHALL be written into slot k of the fill bank on the edge after the pop, through a one-cycle-delayed write-enable and slot index.
REQ-020 o_tile_valid SHALL rise on the same edge that writes slot TILE_WORDS-1, so that with uninterrupted ready the latency from the first pop to o_tile_valid is TILE_WORDS+1 cycles; the FSM then enters PRESENT.
REQ-021 In PRESENT, o_tile_data and o_tile_idx SHALL stay stable until a cycle in which o_tile_valid=1 and i_tile_ready=1.
REQ-022 On that handshake for a tile with index below NUM_TILES-1, the block SHALL increment the tile index and return to FETCH.
REQ-023 On that handshake for tile NUM_TILES-1, the block SHALL go to DONE; DONE SHALL assert o_load_w_finish for exactly one cycle and then go to IDLE.
REQ-024 The block SHALL never issue more than NUM_TILES*TILE_WORDS pops per matrix; o_weight_rd SHALL be 0 in IDLE and DONE.
REQ-025 o_tile_valid SHALL deassert on the edge following the final handshake.

Reset
REQ-026 While s_rst_n=0, the block SHALL force state to IDLE, all counters to 0, tile banks to 0, and o_weight_rd, o_tile_valid, o_load_w_finish and o_busy to 0.
REQ-027 A reset asserted mid-matrix SHALL discard partial tiles and pending FIFO returns, and SHALL NOT generate o_load_w_finish.

Configuration
REQ-028 The macro WEIGHT_TILE_LOADER_DOUBLE_BUF_EN SHALL select between single and double buffering.
REQ-029 When WEIGHT_TILE_LOADER_DOUBLE_BUF_EN is defined, the block SHALL use two banks: filling of tile n+1 SHALL proceed during PRESENT of tile n, pops SHALL stall only while both banks are full, and o_tile_data SHALL come from the presenting bank.
REQ-030 With double buffering, back-to-back tiles under constant ready SHALL be presented with no idle cycle between handshakes once filling has run ahead of presentation.
REQ-031 When WEIGHT_TILE_LOADER_DOUBLE_BUF_EN is not defined, the block SHALL use one bank and SHALL issue no pops during PRESENT.

Structure
REQ-032 The FSM state encodings and the TILE_WORDS/NUM_TILES defaults SHALL be defined in the shared hyper_para include alongside `DATA_WIDTH.
REQ-033 The tile bank SHALL be a sub-module, weight_tile_bank (write port: slot and data; read port: flat tile), instantiated once or twice according to WEIGHT_TILE_LOADER_DOUBLE_BUF_EN.

Verification
REQ-034 Scenario: TILE_WORDS=16, NUM_TILES=2, ready held 1, i_tile_ready held 1, data = word counter -> 16 contiguous pops; o_tile_valid at cycle 17 after the first pop; slot k = k; 32 pops total; o_load_w_finish is a single pulse.
REQ-035 Scenario: i_weight_ready dropped for 5 cycles after pop 7 -> o_weight_rd is 0 during the gap; tile contents are still 0..15 in order; o_tile_valid is delayed by 5 cycles.
REQ-036 Scenario: i_tile_ready held 0 for 20 cycles -> o_tile_data and o_tile_idx are stable; with the macro undefined there are no pops; with it defined exactly 16 pops then a stall.
REQ-037 Scenario: i_start pulsed during FETCH -> no effect; exactly NUM_TILES*TILE_WORDS pops per matrix.
REQ-038 Scenario: s_rst_n pulsed low after pop 9 of tile 1 -> all outputs 0; no finish pulse; a subsequent i_start restarts cleanly at tile 0.
